hex_display_ctrl: RTL and testbench

Time-multiplexed four-digit hexadecimal display driver that consumes the 16-bit output of the loadable data register and shows it on the board's common-anode 7-segment display. A prescaler sets the digit refresh rate. A digit-select counter rotates the anodes. The displayed word is snapshotted once per full scan so all four digits always come from the same register value. Optional leading-zero blanking is provided.

---
 rtl/display_pkg.sv | 25 ++
 rtl/hex_to_7seg.sv | 32 +++
 rtl/hex_display_ctrl.sv | 101 ++++++++++
 tb/tb_hex_display_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants for the board's active-low 7-segment displays.
// Segment patterns are ordered {g,f,e,d,c,b,a}.
package display_pkg;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational nibble to active-low 7-segment pattern decoder.
// Shared by the display blocks of the board.
module hex_to_7seg
    import display_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        unique case (nib)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/hex_display_ctrl.sv
// Four-digit multiplexed hex display driver for a common-anode display.
// The word is snapshotted once per scan so all digits show one value.
module hex_display_ctrl
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 100_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] PMAX = PW'(REFRESH_DIV - 1);

    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [1:0]    idx_q, idx_d;
    logic          primed_q, primed_d;
    logic [15:0]   snap_val_q, snap_val_d;
    logic          snap_lz_q, snap_lz_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic          tick;
    logic          load;
    logic [3:0]    nz;
    logic [3:0]    blank_vec;
    logic [3:0]    nib;
    logic [6:0]    dec_seg;

    assign tick = (pcnt_q == PMAX);
    // Priming edge and end-of-scan edge share one load path.
    assign load = !primed_q || (tick && idx_q == 2'd3);

    always_comb begin
        pcnt_d     = tick ? '0 : pcnt_q + PW'(1);
        idx_d      = tick ? idx_q + 2'd1 : idx_q;
        primed_d   = 1'b1;
        snap_val_d = load ? value : snap_val_q;
        snap_lz_d  = load ? blank_lz : snap_lz_q;
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            nz[k] = (snap_val_q[4*k +: 4] != 4'h0);
        end
        blank_vec[0] = 1'b0;
        blank_vec[3] = snap_lz_q && !nz[3];
        blank_vec[2] = blank_vec[3] && !nz[2];
        blank_vec[1] = blank_vec[2] && !nz[1];
    end

    assign nib = 4'(snap_val_q >> {idx_q, 2'b00});

    hex_to_7seg u_dec (
        .nib (nib),
        .seg (dec_seg)
    );

    always_comb begin
        an_d  = ~(4'b0001 << idx_q);
        seg_d = dec_seg;
        dp_d  = 1'b1;
        if (blank_vec[idx_q]) begin
            an_d  = AN_OFF;
            seg_d = SEG_BLANK;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt_q     <= '0;
            idx_q      <= 2'd0;
            primed_q   <= 1'b0;
            snap_val_q <= 16'h0000;
            snap_lz_q  <= 1'b0;
            an_q       <= AN_OFF;
            seg_q      <= SEG_BLANK;
            dp_q       <= 1'b1;
        end else begin
            pcnt_q     <= pcnt_d;
            idx_q      <= idx_d;
            primed_q   <= primed_d;
            snap_val_q <= snap_val_d;
            snap_lz_q  <= snap_lz_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench for hex_display_ctrl with a 4-cycle digit slot.
// Expected outputs are queued per cycle and checked after each edge.
module tb_hex_display_ctrl;

    localparam int DIV = 4;

    localparam logic [3:0] AN0  = 4'b1110;
    localparam logic [3:0] AN1  = 4'b1101;
    localparam logic [3:0] AN2  = 4'b1011;
    localparam logic [3:0] AN3  = 4'b0111;
    localparam logic [3:0] AOFF = 4'b1111;
    localparam logic [6:0] SOFF = 7'b1111111;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        string      tag;
    } exp_t;

    logic [6:0] segtab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] value = 16'h0000;
    logic        blank_lz = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    exp_t sb[$];
    int   passed = 0;
    int   failed = 0;
    int   total  = 0;

    hex_display_ctrl #(.REFRESH_DIV(DIV)) dut (
        .clk      (clk),
        .reset    (reset),
        .value    (value),
        .blank_lz (blank_lz),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    always #5 clk = ~clk;

    task automatic chk(input exp_t e);
        total++;
        assert (an === e.an) passed++;
        else begin
            failed++;
            $error("FAIL %s an: got %b want %b", e.tag, an, e.an);
        end
        total++;
        assert (seg === e.seg) passed++;
        else begin
            failed++;
            $error("FAIL %s seg: got %b want %b", e.tag, seg, e.seg);
        end
        total++;
        assert (dp === 1'b1) passed++;
        else begin
            failed++;
            $error("FAIL %s dp: got %b want 1", e.tag, dp);
        end
        total++;
        assert (($countones(~an) <= 1) === 1'b1) passed++;
        else begin
            failed++;
            $error("FAIL %s an_overlap: got %b want at most one low", e.tag, an);
        end
    endtask

    task automatic cyc(input logic [3:0] ea, input logic [6:0] es,
                       input string tag);
        sb.push_back('{an: ea, seg: es, tag: tag});
        @(posedge clk);
        #1;
        chk(sb.pop_front());
    endtask

    task automatic slot(input logic [3:0] ea, input logic [6:0] es,
                        input string tag);
        repeat (DIV) cyc(ea, es, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1;
        value    = 16'h1234;
        blank_lz = 1'b0;
        reset    = 1'b1;
        cyc(AOFF, SOFF, "in_reset");
        cyc(AOFF, SOFF, "in_reset");
        reset = 1'b0;

        cyc(AN0, segtab[0], "prime_e1");
        value = 16'hABCD;
        repeat (3) cyc(AN0, segtab[4], "prime_d0");
        slot(AN1, segtab[3], "s1234_d1");
        slot(AN2, segtab[2], "s1234_d2");
        slot(AN3, segtab[1], "s1234_d3");

        slot(AN0, segtab[13], "scan_d");
        value = 16'h0000;
        slot(AN1, segtab[12], "scan_C");
        slot(AN2, segtab[11], "scan_b");
        slot(AN3, segtab[10], "scan_A");
        slot(AN0, segtab[0], "zero_d0");

        blank_lz = 1'b1;
        value    = 16'h0050;
        slot(AN1, segtab[0], "zero_d1");
        slot(AN2, segtab[0], "zero_d2");
        slot(AN3, segtab[0], "zero_d3");

        slot(AN0, segtab[0], "lz50_d0");
        slot(AN1, segtab[5], "lz50_d1");
        slot(AOFF, SOFF, "lz50_d2");
        value = 16'h0000;
        slot(AOFF, SOFF, "lz50_d3");

        slot(AN0, segtab[0], "lz0_d0");
        blank_lz = 1'b0;
        value    = 16'h5678;
        slot(AOFF, SOFF, "lz0_d1");
        slot(AOFF, SOFF, "lz0_d2");
        slot(AOFF, SOFF, "lz0_d3");

        slot(AN0, segtab[8], "s5678_d0");
        slot(AN1, segtab[7], "s5678_d1");
        cyc(AN2, segtab[6], "s5678_d2");
        cyc(AN2, segtab[6], "s5678_d2");

        #3;
        value = 16'h9ABC;
        reset = 1'b1;
        sb.push_back('{an: AOFF, seg: SOFF, tag: "async_rst"});
        #1;
        chk(sb.pop_front());
        #2;
        reset = 1'b0;

        cyc(AN0, segtab[0], "reprime_e1");
        repeat (3) cyc(AN0, segtab[12], "s9ABC_d0");
        slot(AN1, segtab[11], "s9ABC_d1");
        slot(AN2, segtab[10], "s9ABC_d2");
        value = 16'h0000;
        slot(AN3, segtab[9], "s9ABC_d3");

        for (int n = 0; n < 16; n++) begin
            logic [3:0] nv;
            nv    = 4'(n + 1);
            value = {4{nv}};
            slot(AN0, segtab[n], "sweep_d0");
            slot(AN1, segtab[n], "sweep_d1");
            slot(AN2, segtab[n], "sweep_d2");
            slot(AN3, segtab[n], "sweep_d3");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
